// File: rtl/pipe_stage_buffer_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stage_buffer_pkg
// Shared constants for the pipe_stage_buffer block and its statistics counter.
//   RESET_ENABLE : level of the reset input that holds the block in reset
//   STALL_ENABLE : level of hold that freezes the stage
//   WRITE_ENABLE : level of the push strobe that writes an entry
//   STAT_W/STAT_MAX : statistics counter width and saturation value
//   sat_next()   : next value of a saturating counter with clear priority
// ----------------------------------------------------------------------------
package pipe_stage_buffer_pkg;

    localparam logic RESET_ENABLE = 1'b0;
    localparam logic STALL_ENABLE = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam int              STAT_W   = 32;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Clear wins over increment; the counter sticks at STAT_MAX.
    function automatic logic [STAT_W-1:0] sat_next(
        input logic [STAT_W-1:0] value,
        input logic              inc,
        input logic              clr
    );
        if (clr) begin
            return '0;
        end
        if (inc && (value != STAT_MAX)) begin
            return value + STAT_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// ----------------------------------------------------------------------------
// pipe_sat_counter
// 32-bit saturating event counter with synchronous clear.
// Ports:
//   clock  in   sole clock
//   reset  in   asynchronous active-low reset
//   inc    in   count one event this cycle
//   clr    in   zero the counter (priority over inc)
//   value  out  current count, saturates at 0xFFFFFFFF
// ----------------------------------------------------------------------------
module pipe_sat_counter
    import pipe_stage_buffer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [STAT_W-1:0] value
);

    logic [STAT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ENABLE) begin
            cnt <= '0;
        end else begin
            cnt <= sat_next(cnt, inc, clr);
        end
    end

    assign value = cnt;

endmodule

// File: rtl/pipe_stage_buffer.sv
// ----------------------------------------------------------------------------
// pipe_stage_buffer
// Elastic pipeline stage: a DEPTH-entry FIFO with valid/ready on both sides,
// a control-unit stall (hold) and a synchronous flush. out_data shows BUBBLE
// whenever no valid entry is presented.
//
// Optional feature: define PIPE_STAGE_STATS_EN to build the hold/bubble/full
// statistics counters. Without it the counter ports read 0 and no counter
// logic exists.
//
// Parameters: DATA_W (payload width), DEPTH (power of two, 1..16),
//             BUBBLE (payload shown when out_valid=0)
// Ports:
//   clock, reset            clock and asynchronous active-low reset
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   hold                    freeze: no push, no pop, state retained
//   flush                   drop all entries at the next edge
//   count                   current occupancy
//   stats_clear             zero the statistics counters
//   hold_cnt, bubble_cnt, full_cnt   statistics counters
// ----------------------------------------------------------------------------
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int                 DATA_W = 32,
    parameter int                 DEPTH  = 2,
    parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        hold,
    input  logic                        flush,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    input  logic                        stats_clear,
    output logic [STAT_W-1:0]           hold_cnt,
    output logic [STAT_W-1:0]           bubble_cnt,
    output logic [STAT_W-1:0]           full_cnt
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  occ;
    logic              run;
    logic              stall;
    logic              push;
    logic              pop;

    // run keeps in_ready low while reset is asserted and rises on the first
    // edge afterwards, so the reset input never feeds in_ready combinationally.
    assign stall     = (hold == STALL_ENABLE);
    assign in_ready  = run & (occ < DEPTH_C) & ~stall & ~flush;
    assign out_valid = (occ != '0) & ~stall & ~flush;
    assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE;
    assign count     = occ;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ENABLE) begin
            run    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            run <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   occ <= occ + CNT_ONE;
                    2'b01:   occ <= occ - CNT_ONE;
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Payload storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push == WRITE_ENABLE) begin
            mem[wr_ptr] <= in_data;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic hold_inc;
    logic bubble_inc;
    logic full_inc;

    assign hold_inc   = stall;
    assign bubble_inc = ~stall & (occ == '0);
    assign full_inc   = in_valid & (occ == DEPTH_C);

    pipe_sat_counter u_hold_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (hold_inc),
        .clr   (stats_clear),
        .value (hold_cnt)
    );

    pipe_sat_counter u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (bubble_inc),
        .clr   (stats_clear),
        .value (bubble_cnt)
    );

    pipe_sat_counter u_full_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (full_inc),
        .clr   (stats_clear),
        .value (full_cnt)
    );
`else
    logic unused_stats_clear;

    assign unused_stats_clear = stats_clear;
    assign hold_cnt           = '0;
    assign bubble_cnt         = '0;
    assign full_cnt           = '0;
`endif

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 Parameter DEPTH, default 2, entry count; power of two, 1..16.
REQ-003 Parameter BUBBLE, default all-zero DATA_W, payload driven when no valid entry is presented.
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream offers in_data.
REQ-007 in_ready  out  1  stage accepts in_data this cycle.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 out_valid  out  1  out_data holds a valid entry.
REQ-010 out_ready  in  1  downstream consumes out_data this cycle.
REQ-011 out_data  out  DATA_W  head entry, or BUBBLE when out_valid=0.
REQ-012 hold  in  1  control-unit stall; freezes the stage.
REQ-013 flush  in  1  discard all entries.
REQ-014 count  out  clog2(DEPTH+1)  current occupancy.
REQ-015 stats_clear  in  1  zero the statistics counters.
REQ-016 hold_cnt, bubble_cnt, full_cnt  out  32 each  statistics counters.

Function
REQ-017 Push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 in_ready = (count < DEPTH) & ~hold & ~flush; no combinational path from out_ready to in_ready.
REQ-019 out_valid = (count != 0) & ~hold & ~flush; out_data = head entry when out_valid, else BUBBLE.
REQ-020 Latency: a word pushed in cycle N is presented at out_data no earlier than cycle N+1; strict FIFO order.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-022 Read and write pointers wrap modulo DEPTH; full is count==DEPTH, empty is count==0.
REQ-023 Sustained throughput is 1 word/cycle for DEPTH>=2; DEPTH=1 gives 1 word per 2 cycles.
REQ-024 hold=1: no push, no pop; entries, pointers and count are retained.
REQ-025 flush=1 (synchronous): count and pointers go to 0 at the next edge; flush overrides hold, push and pop.
REQ-026 Entry storage needs no reset; only pointers, count and counters are reset.

Reset
REQ-027 reset=0 immediately forces count=0 and pointers=0, and so out_valid=0, out_data=BUBBLE and in_ready=0, plus all counters=0, including mid-transfer.
REQ-028 On the first edge after reset deasserts, in_ready=1 when hold=0 and flush=0.

Configuration
REQ-029 Macro PIPE_STAGE_STATS_EN defined: hold_cnt counts cycles with hold=1; bubble_cnt counts cycles with hold=0 and count==0; full_cnt counts cycles with in_valid=1 and count==DEPTH.
REQ-030 All counters saturate at 0xFFFFFFFF, clear on stats_clear (stats_clear has priority over increment), and are not affected by flush.
REQ-031 Macro undefined: counter ports remain present, are tied to 0, and no counter logic is synthesised.

Structure
REQ-032 The shared defines file holds RESET_ENABLE (1'b0 for this block), and the STALL_ENABLE and WRITE_ENABLE constants.
REQ-033 One sub-module, pipe_sat_counter (32-bit saturating counter with inc/clr), is instantiated three times under PIPE_STAGE_STATS_EN.

Verification (DATA_W=32, DEPTH=4, BUBBLE=0)
REQ-034 Fill 3 entries, then pulse reset low mid-cycle -> count=0, out_valid=0 and out_data=0 without waiting for a clock edge.
REQ-035 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4 and in_ready=0; then out_ready=1 -> 0x11,0x22,0x33,0x44 in four consecutive cycles.
REQ-036 Stream 10 words 1..10 with in_valid=out_ready=1 -> first word out one cycle after push, then one word per cycle, count steady at 1, order preserved across two pointer wraps.
REQ-037 count=2, flush=1 with in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, and the offered word is never output.
REQ-038 count=2, hold=1 for 3 cycles -> out_valid=0, out_data=0, count=2 throughout; then hold=0 -> both entries drain in order; with stats built, hold_cnt=3.
REQ-039 Stats build: force hold_cnt to 0xFFFFFFFE and hold for 3 cycles -> 0xFFFFFFFF with no wrap; stats_clear=1 -> 0 at the next edge.
